// File: rtl/pixel_timing_gen.sv
// Raster timing generator: qualifies the PLL lock, then emits hsync/vsync/de and pixel coordinates.
// Optional colour-bar output rgb is built when PIXEL_TIMING_TEST_PATTERN_EN is defined.
module pixel_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 40,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 13,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 29,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_locked,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        frame_start,
`ifdef PIXEL_TIMING_TEST_PATTERN_EN
    output logic [23:0] rgb,
`endif
    output logic        running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int QW      = $clog2(LOCK_CYCLES + 1);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [QW-1:0] Q_LAST = QW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_RUN} state_t;

    state_t        state_q, state_d;
    logic          lock_meta_q, lock_sync_q;
    logic [QW-1:0] qual_q, qual_d;
    logic [10:0]   h_q, h_d;
    logic [9:0]    v_q, v_d;

    logic          hsync_q, vsync_q, de_q, fs_q, running_q;
    logic          hsync_d, vsync_d, de_d, fs_d, running_d;
    logic [10:0]   pix_x_q, pix_x_d;
    logic [9:0]    pix_y_q, pix_y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            qual_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                qual_d = '0;
                h_d    = '0;
                v_d    = '0;
                if (enable && lock_sync_q) state_d = S_QUALIFY;
            end
            S_QUALIFY: begin
                h_d = '0;
                v_d = '0;
                if (!enable) begin
                    state_d = S_IDLE;
                    qual_d  = '0;
                end else if (!lock_sync_q) begin
                    qual_d = '0;
                end else if (qual_q == Q_LAST) begin
                    state_d = S_RUN;
                    qual_d  = '0;
                end else begin
                    qual_d = qual_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_sync_q) begin
                    state_d = S_QUALIFY;
                    h_d     = '0;
                    v_d     = '0;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        // a pending stop only takes effect at the frame boundary
                        v_d = '0;
                        if (!enable) state_d = S_IDLE;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output stage: decode of the current counters, registered one clock behind them
    always_comb begin
        de_d      = (state_q == S_RUN) && (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d   = !((state_q == S_RUN) && (h_q >= HS_BEG) && (h_q < HS_END));
        vsync_d   = !((state_q == S_RUN) && (v_q >= VS_BEG) && (v_q < VS_END));
        pix_x_d   = de_d ? h_q : '0;
        pix_y_d   = de_d ? v_q : '0;
        fs_d      = de_d && (h_q == '0) && (v_q == '0);
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            de_q      <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            fs_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            fs_q      <= fs_d;
            running_q <= running_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = fs_q;
    assign running     = running_q;

`ifdef PIXEL_TIMING_TEST_PATTERN_EN
    logic [23:0] rgb_q, rgb_d;

    function automatic logic [23:0] bar_colour(input logic [10:0] x);
        logic [2:0] bar;
        bar = 3'(({21'd0, x} * 32'd8) / 32'(H_ACTIVE));
        case (bar)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    always_comb rgb_d = de_d ? bar_colour(h_q) : 24'h000000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb_q <= 24'h000000;
        else        rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;
`endif

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed bench for pixel_timing_gen with a 15x8 raster (H 8/2/3/2, V 4/1/2/1) and LOCK_CYCLES=4.
`timescale 1ns/1ps
module tb_pixel_timing_gen;
    logic        clk = 1'b0;
    logic        rst_n, pll_locked, enable;
    logic        hsync, vsync, de, frame_start, running;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
`ifdef PIXEL_TIMING_TEST_PATTERN_EN
    logic [23:0] rgb;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pixel_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .LOCK_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .enable(enable),
        .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start),
`ifdef PIXEL_TIMING_TEST_PATTERN_EN
        .rgb(rgb),
`endif
        .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst_n = 1'b0; pll_locked = 1'b0; enable = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({hsync, vsync} !== 2'b11) $display("FAIL reset_sync: got %b want 11", {hsync, vsync}); else n_pass++;
        n_checks++; if ({de, frame_start, running} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {de, frame_start, running}); else n_pass++;
        n_checks++; if ({pix_x, pix_y} !== 21'd0) $display("FAIL reset_pix: got %0d,%0d want 0,0", pix_x, pix_y); else n_pass++;
    endtask

    task automatic test_startup(input string tag);
        pll_locked = 1'b1; enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_checks++; if ({running, de} !== 2'b00) $display("FAIL %s_early cyc%0d: running,de=%b want 00", tag, i, {running, de}); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (running !== 1'b1) $display("FAIL %s_running_rise: got %b want 1", tag, running); else n_pass++;
        n_checks++; if (frame_start !== 1'b0) $display("FAIL %s_fs_early: got %b want 0", tag, frame_start); else n_pass++;
        @(negedge clk);
        n_checks++; if ({frame_start, de} !== 2'b11) $display("FAIL %s_first_pixel: fs,de=%b want 11", tag, {frame_start, de}); else n_pass++;
        n_checks++; if ({pix_x, pix_y} !== 21'd0) $display("FAIL %s_first_pix: got %0d,%0d want 0,0", tag, pix_x, pix_y); else n_pass++;
    endtask

    task automatic test_timing;
        int h, v, de_cnt, hs_cnt, vs_cnt, fs_cnt;
        logic e_de, e_hs, e_vs, e_fs;
        logic [10:0] e_x;
        logic [9:0]  e_y;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 240; k++) begin
            h = k % 15; v = (k / 15) % 8;
            e_de = (h < 8) && (v < 4);
            e_hs = !((h >= 10) && (h < 13));
            e_vs = !((v >= 5) && (v < 7));
            e_fs = (h == 0) && (v == 0);
            e_x  = e_de ? 11'(h) : 11'd0;
            e_y  = e_de ? 10'(v) : 10'd0;
            n_checks++; if (de !== e_de) $display("FAIL run_de k%0d: got %b want %b", k, de, e_de); else n_pass++;
            n_checks++; if (hsync !== e_hs) $display("FAIL run_hsync k%0d: got %b want %b", k, hsync, e_hs); else n_pass++;
            n_checks++; if (vsync !== e_vs) $display("FAIL run_vsync k%0d: got %b want %b", k, vsync, e_vs); else n_pass++;
            n_checks++; if (frame_start !== e_fs) $display("FAIL run_fs k%0d: got %b want %b", k, frame_start, e_fs); else n_pass++;
            n_checks++; if ({pix_x, pix_y} !== {e_x, e_y}) $display("FAIL run_pix k%0d: got %0d,%0d want %0d,%0d", k, pix_x, pix_y, e_x, e_y); else n_pass++;
            n_checks++; if (running !== 1'b1) $display("FAIL run_running k%0d: got %b want 1", k, running); else n_pass++;
            de_cnt += int'(de); hs_cnt += int'(!hsync); vs_cnt += int'(!vsync); fs_cnt += int'(frame_start);
            @(negedge clk);
        end
        n_checks++; if (de_cnt !== 64) $display("FAIL run_de_total: got %0d want 64", de_cnt); else n_pass++;
        n_checks++; if (hs_cnt !== 48) $display("FAIL run_hsync_total: got %0d want 48", hs_cnt); else n_pass++;
        n_checks++; if (vs_cnt !== 60) $display("FAIL run_vsync_total: got %0d want 60", vs_cnt); else n_pass++;
        n_checks++; if (fs_cnt !== 2) $display("FAIL run_fs_total: got %0d want 2", fs_cnt); else n_pass++;
        n_checks++; if (frame_start !== 1'b1) $display("FAIL run_frame_period: fs=%b want 1 at k=240", frame_start); else n_pass++;
    endtask

    task automatic test_async_reset;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({hsync, vsync} !== 2'b11) $display("FAIL arst_sync: got %b want 11", {hsync, vsync}); else n_pass++;
        n_checks++; if ({de, frame_start, running} !== 3'b000) $display("FAIL arst_flags: got %b want 000", {de, frame_start, running}); else n_pass++;
        n_checks++; if ({pix_x, pix_y} !== 21'd0) $display("FAIL arst_pix: got %0d,%0d want 0,0", pix_x, pix_y); else n_pass++;
        test_startup("restart");
    endtask

    task automatic test_lock_loss;
        logic e_run;
        repeat (20) @(negedge clk);
        pll_locked = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 2) pll_locked = 1'b1;
            e_run = (i <= 2) || (i >= 8);
            n_checks++; if (running !== e_run) $display("FAIL lock_running cyc%0d: got %b want %b", i, running, e_run); else n_pass++;
            n_checks++; if (frame_start !== (i == 9)) $display("FAIL lock_fs cyc%0d: got %b want %b", i, frame_start, (i == 9)); else n_pass++;
            if (i >= 4 && i <= 8) begin
                n_checks++; if ({de, hsync, vsync, pix_x, pix_y} !== {3'b011, 21'd0})
                    $display("FAIL lock_idle_out cyc%0d: de,hs,vs=%b pix=%0d,%0d want 011 0,0", i, {de, hsync, vsync}, pix_x, pix_y);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lock_toggle;
        bit found;
        pll_locked = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (i % 3 == 0) pll_locked = ~pll_locked;
            if (i >= 3) begin
                n_checks++; if ({running, frame_start} !== 2'b00) $display("FAIL toggle_run cyc%0d: running,fs=%b want 00", i, {running, frame_start}); else n_pass++;
            end
        end
        pll_locked = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (frame_start === 1'b1);
        end
        n_checks++; if (!found) $display("FAIL toggle_recover: frame_start not seen within 20 clocks, want seen"); else n_pass++;
    endtask

    task automatic test_enable_cancel;
        int drops;
        drops = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 18) enable = 1'b0;
            if (k == 50) enable = 1'b1;
            drops += int'(!running);
        end
        n_checks++; if (drops !== 0) $display("FAIL cancel_running: low for %0d clocks want 0", drops); else n_pass++;
        n_checks++; if (frame_start !== 1'b1) $display("FAIL cancel_next_frame: fs=%b want 1", frame_start); else n_pass++;
    endtask

    task automatic test_enable_stop;
        int h, v;
        logic e_de;
        for (int k = 1; k <= 160; k++) begin
            @(negedge clk);
            if (k == 18) begin
                n_checks++; if ({de, pix_x, pix_y} !== {1'b1, 11'd3, 10'd1}) $display("FAIL stop_at_pixel: de=%b pix=%0d,%0d want 1 3,1", de, pix_x, pix_y); else n_pass++;
                enable = 1'b0;
            end
            h = k % 15; v = (k / 15) % 8;
            e_de = (k < 120) && (h < 8) && (v < 4);
            n_checks++; if (running !== (k < 119)) $display("FAIL stop_running k%0d: got %b want %b", k, running, (k < 119)); else n_pass++;
            n_checks++; if (de !== e_de) $display("FAIL stop_de k%0d: got %b want %b", k, de, e_de); else n_pass++;
            n_checks++; if (frame_start !== 1'b0) $display("FAIL stop_fs k%0d: got %b want 0", k, frame_start); else n_pass++;
        end
    endtask

`ifdef PIXEL_TIMING_TEST_PATTERN_EN
    task automatic test_pattern;
        logic [23:0] bars [8];
        logic [23:0] e_rgb;
        bit found;
        int h;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        n_checks++; if (rgb !== 24'h000000) $display("FAIL pat_idle: got %h want 000000", rgb); else n_pass++;
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = (frame_start === 1'b1);
        end
        n_checks++; if (!found) $display("FAIL pat_start: frame_start not seen within 20 clocks, want seen"); else n_pass++;
        for (int k = 0; k < 30; k++) begin
            h = k % 15;
            e_rgb = (h < 8) ? bars[h] : 24'h000000;
            n_checks++; if (rgb !== e_rgb) $display("FAIL pat_rgb k%0d: got %h want %h", k, rgb, e_rgb); else n_pass++;
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_startup("startup");
        test_timing();
        test_async_reset();
        test_lock_loss();
        test_lock_toggle();
        test_enable_cancel();
        test_enable_stop();
`ifdef PIXEL_TIMING_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pixel_timing_gen.md
PIXEL_TIMING_GEN -- requirements
Module: pixel_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 48, hsync width in clocks.
REQ-004 Parameter H_BP, default 40, horizontal back porch in clocks.
REQ-005 Parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 480 / 13 / 3 / 29, vertical equivalents in lines.
REQ-006 Parameter LOCK_CYCLES, default 1024, consecutive synchronized-lock clocks required before the timing generator starts.
REQ-007 clk  input  1  pixel clock, the 35 MHz PLL output clock; all logic on its rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-010 enable  input  1  run request; low holds the generator idle.
REQ-011 hsync  output  1  horizontal sync, active low.
REQ-012 vsync  output  1  vertical sync, active low.
REQ-013 de  output  1  data enable, high during active pixels.
REQ-014 pix_x  output  11  column of current active pixel, 0 outside active.
REQ-015 pix_y  output  10  row of current active pixel, 0 outside active.
REQ-016 frame_start  output  1  one-clock pulse at first active pixel (0,0) of each frame.
REQ-017 running  output  1  high while in RUN state.

Function
REQ-018 pll_locked SHALL pass through a two-flop synchronizer before any use.
REQ-019 The FSM SHALL have states IDLE, QUALIFY, RUN; IDLE->QUALIFY when enable and synchronized lock are both high.
REQ-020 QUALIFY SHALL count consecutive synchronized-lock-high clocks; reaching LOCK_CYCLES -> RUN with h_cnt=v_cnt=0; lock low -> counter cleared, stay QUALIFY; enable low -> IDLE.
REQ-021 In RUN, h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params) and wrap to 0, incrementing v_cnt, which wraps at V_TOTAL-1 to 0.
REQ-022 Line order SHALL be active, front porch, sync, back porch; same order vertically.
REQ-023 hsync SHALL be low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v_cnt, full lines.
REQ-024 de SHALL be high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; pix_x/pix_y then equal h_cnt/v_cnt.
REQ-025 All outputs SHALL be registered, one clock after the counter values they decode.
REQ-026 frame_start SHALL be high for exactly one clock, coincident with de for pixel (0,0).
REQ-027 Synchronized lock falling in RUN SHALL force QUALIFY next clock, with hsync=vsync=1, de=0, pix_x=pix_y=0, frame_start=0 from the following clock; counters restart from 0 on re-qualification.
REQ-028 enable falling in RUN SHALL complete the current frame, then enter IDLE at the wrap of v_cnt to 0; enable re-asserted before the wrap cancels the stop.
REQ-029 In IDLE and QUALIFY outputs SHALL be held inactive: hsync=1, vsync=1, de=0, pix_x=0, pix_y=0, frame_start=0, running=0.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, clear synchronizer, qualify counter and h_cnt/v_cnt, and drive all outputs to inactive values per REQ-029.
REQ-031 Reset release SHALL be synchronous to clk; the first state change occurs no earlier than the third rising edge after release.

Configuration
REQ-032 With macro PIXEL_TIMING_TEST_PATTERN_EN defined, an extra output rgb (24 bits) SHALL carry eight equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black, by pix_x*8/H_ACTIVE), registered with de and zero when de is low.
REQ-033 Without PIXEL_TIMING_TEST_PATTERN_EN the rgb port and its logic SHALL not exist.

Verification (H 8/2/3/2, V 4/1/2/1, LOCK_CYCLES=4)
REQ-034 rst_n low mid-frame -> all outputs inactive same cycle; after release with lock+enable high, running rises 2+4+1 clocks later, frame_start one clock after.
REQ-035 Steady run -> line period 15 clocks, de high 8 clocks, hsync low 3 clocks starting 10 clocks after de rises; frame period 120 clocks, vsync low 30 clocks.
REQ-036 pll_locked pulsed low 2 clocks in RUN -> running and de drop within 4 clocks; frame_start reappears only after 4 consecutive qualified clocks.
REQ-037 pll_locked toggling every 3 clocks in QUALIFY -> running never rises.
REQ-038 enable dropped at pixel (3,1) -> frame finishes, running falls at v_cnt wrap, no further frame_start.
REQ-039 With PIXEL_TIMING_TEST_PATTERN_EN -> pix_x 0 gives rgb FFFFFF, pix_x 7 gives 000000, rgb 000000 whenever de=0.
